// File: rtl/piso_tx_arbiter.sv
// Round-robin scheduler that feeds one LSB-first PISO serializer from N_REQ requesters
// and frames the serial bit-times with valid/first/last/source strobes.
module piso_tx_arbiter #(
  parameter int WIDTH = 9,
  parameter int N_REQ = 2,
  parameter int GAP   = 1,
  localparam int SRC_W = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   piso_load,
  output logic [WIDTH-1:0]       piso_data,
  output logic                   ser_valid,
  output logic                   ser_first,
  output logic                   ser_last,
  output logic [SRC_W-1:0]       ser_src,
  output logic                   busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [3:0]       GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic [3:0]       gap_cnt;
  logic [SRC_W-1:0] last_grant;
  logic [SRC_W-1:0] src_q;
  logic             grant_any;
  logic [SRC_W-1:0] grant_idx;
  logic             frame_end;
  logic             grant_en;
  logic             grant_fire;

  assign frame_end  = (state == S_SHIFT) && (bit_cnt == LAST_BIT);
  assign grant_en   = (state == S_IDLE) || (frame_end && (GAP == 0));
  // Grants are held off while reset is asserted so no handshake completes into a reset.
  assign grant_fire = rst_n && grant_en && grant_any;
  assign ser_src    = src_q;

  // Round-robin pick: nearest valid requester after the last one served.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!grant_any && req_valid[i] &&
            (i == ((int'(last_grant) + k >= N_REQ) ? int'(last_grant) + k - N_REQ
                                                    : int'(last_grant) + k))) begin
          grant_any = 1'b1;
          grant_idx = SRC_W'(i);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (grant_fire) state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        if (frame_end) begin
          if (GAP > 0)         state_nxt = S_GAP;
          else if (grant_fire) state_nxt = S_SHIFT;
          else                 state_nxt = S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bit/gap counters saturate at their terminal values; a grant restarts the bit count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      last_grant <= SRC_W'(N_REQ - 1);
      src_q      <= '0;
    end else begin
      if (grant_fire) begin
        bit_cnt    <= '0;
        last_grant <= grant_idx;
        src_q      <= grant_idx;
      end else if ((state == S_SHIFT) && (bit_cnt != LAST_BIT)) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (frame_end) begin
        gap_cnt <= '0;
      end else if ((state == S_GAP) && (gap_cnt != GAP_LAST)) begin
        gap_cnt <= gap_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    piso_load = grant_fire;
    piso_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_fire && (grant_idx == SRC_W'(i))) begin
        req_ready[i] = 1'b1;
        piso_data    = req_data[i*WIDTH +: WIDTH];
      end
    end
    ser_valid = (state == S_SHIFT);
    ser_first = (state == S_SHIFT) && (bit_cnt == '0);
    ser_last  = frame_end;
    busy      = (state != S_IDLE);
  end

endmodule

// File: tb/tb_piso_tx_arbiter.sv
// Bench for piso_tx_arbiter: GAP=1 and GAP=0 instances share stimulus and are checked
// against a slot-based frame model plus scenario-specific checks.
module tb_piso_tx_arbiter;
  localparam int W = 9;
  localparam int N = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data = '0;

  logic [N-1:0] o_rdy   [2];
  logic         o_load  [2];
  logic [W-1:0] o_pdata [2];
  logic         o_sv    [2];
  logic         o_sf    [2];
  logic         o_sl    [2];
  logic [0:0]   o_src   [2];
  logic         o_busy  [2];

  logic [W-1:0] sreg    [2];
  logic         ser_bit [2];

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model: slot 0 = idle, 1..W = frame bit slot-1, W+1..W+gap = forced gap.
  int           m_slot [2];
  int           m_ptr  [2];
  int           m_src  [2];
  logic [W-1:0] m_word [2];
  int           n_slot [2];
  int           n_ptr  [2];
  int           n_src  [2];
  logic [W-1:0] n_word [2];

  always #5 clk = ~clk;

  piso_tx_arbiter #(.WIDTH(W), .N_REQ(N), .GAP(1)) u_gap1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(o_rdy[0]), .piso_load(o_load[0]), .piso_data(o_pdata[0]),
    .ser_valid(o_sv[0]), .ser_first(o_sf[0]), .ser_last(o_sl[0]),
    .ser_src(o_src[0]), .busy(o_busy[0])
  );

  piso_tx_arbiter #(.WIDTH(W), .N_REQ(N), .GAP(0)) u_gap0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(o_rdy[1]), .piso_load(o_load[1]), .piso_data(o_pdata[1]),
    .ser_valid(o_sv[1]), .ser_first(o_sf[1]), .ser_last(o_sl[1]),
    .ser_src(o_src[1]), .busy(o_busy[1])
  );

  // Stand-in for the shared-reset LSB-first serializer each instance drives.
  always_ff @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (!rst_n)         sreg[u] <= '0;
      else if (o_load[u]) sreg[u] <= o_pdata[u];
      else                sreg[u] <= sreg[u] >> 1;
    end
  end
  assign ser_bit[0] = sreg[0][0];
  assign ser_bit[1] = sreg[1][0];

  initial begin
    for (int u = 0; u < 2; u++) begin
      m_slot[u] = 0; m_ptr[u] = N - 1; m_src[u] = 0; m_word[u] = '0;
    end
  end

  task automatic sample();
    logic [16:0]  got;
    logic [16:0]  exp;
    logic [N-1:0] er;
    logic [W-1:0] ed;
    int           c;
    int           gp;
    bit           g;
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      gp = (u == 0) ? 1 : 0;
      g  = 1'b0;
      c  = 0;
      if (rst_n && (m_slot[u] == 0 || (gp == 0 && m_slot[u] == W))) begin
        for (int k = 1; k <= N; k++) begin
          int cc;
          cc = (m_ptr[u] + k) % N;
          if (!g && req_valid[cc]) begin g = 1'b1; c = cc; end
        end
      end
      er  = g ? N'(1 << c) : '0;
      ed  = g ? req_data[c*W +: W] : '0;
      exp = {er, g, ed, (m_slot[u] >= 1 && m_slot[u] <= W), (m_slot[u] == 1),
             (m_slot[u] == W), (m_slot[u] != 0), 1'(m_src[u])};
      got = {o_rdy[u], o_load[u], o_pdata[u], o_sv[u], o_sf[u], o_sl[u], o_busy[u], o_src[u]};
      if (chk_en) begin
        total++;
        if (got !== exp) begin
          bad++;
          $display("FAIL model_outputs inst%0d t=%0t got=%h want=%h", u, $time, got, exp);
        end
        if (m_slot[u] >= 1 && m_slot[u] <= W) begin
          total++;
          if (ser_bit[u] !== m_word[u][m_slot[u]-1]) begin
            bad++;
            $display("FAIL serial_bit inst%0d t=%0t got=%b want=%b", u, $time, ser_bit[u],
                     m_word[u][m_slot[u]-1]);
          end
        end
      end
      n_ptr[u] = m_ptr[u]; n_src[u] = m_src[u]; n_word[u] = m_word[u];
      if (!rst_n) begin
        n_slot[u] = 0; n_ptr[u] = N - 1; n_src[u] = 0;
      end else if (g) begin
        n_slot[u] = 1; n_ptr[u] = c; n_src[u] = c; n_word[u] = ed;
      end else if (m_slot[u] == 0) begin
        n_slot[u] = 0;
      end else if (m_slot[u] >= W + gp) begin
        n_slot[u] = 0;
      end else begin
        n_slot[u] = m_slot[u] + 1;
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      m_slot[u] = n_slot[u]; m_ptr[u] = n_ptr[u]; m_src[u] = n_src[u]; m_word[u] = n_word[u];
    end
  endtask

  task automatic cyc();
    sample();
    advance();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    repeat (2) cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = '0;
    repeat (2) cyc();
    chk_en = 1'b1;
    sample();
    for (int u = 0; u < 2; u++) begin
      total++;
      if ({o_rdy[u], o_load[u], o_pdata[u], o_sv[u], o_sf[u], o_sl[u], o_src[u], o_busy[u]} !== '0) begin
        bad++;
        $display("FAIL reset_outputs inst%0d got=%h want=0", u,
                 {o_rdy[u], o_load[u], o_pdata[u], o_sv[u], o_sf[u], o_sl[u], o_src[u], o_busy[u]});
      end
    end
    advance();
    rst_n = 1'b1;
  endtask

  task automatic test_single_frame();
    logic [W-1:0] bits;
    int           exp_bits [W] = '{1, 0, 1, 0, 0, 1, 0, 1, 1};
    int           rdy_cnt;
    do_reset();
    req_data  = {9'h0AB, 9'h1A5};
    req_valid = 2'b01;
    sample();
    total++;
    if (o_rdy[0] !== 2'b01) begin
      bad++; $display("FAIL single_grant got=%b want=01", o_rdy[0]);
    end
    advance();
    req_valid = '0;
    rdy_cnt = 0;
    bits = '0;
    for (int k = 0; k < W; k++) begin
      sample();
      if (o_rdy[0] != '0) rdy_cnt++;
      total++;
      if (o_sv[0] !== 1'b1 || ser_bit[0] !== 1'(exp_bits[k]) || o_sf[0] !== (k == 0) ||
          o_sl[0] !== (k == W - 1) || o_src[0] !== 1'b0) begin
        bad++;
        $display("FAIL single_bit%0d got v=%b b=%b f=%b l=%b s=%b want v=1 b=%0d", k,
                 o_sv[0], ser_bit[0], o_sf[0], o_sl[0], o_src[0], exp_bits[k]);
      end
      advance();
    end
    sample();
    total++;
    if (o_sv[0] !== 1'b0 || rdy_cnt != 0) begin
      bad++; $display("FAIL single_end got sv=%b extra_ready=%0d want sv=0 extra_ready=0", o_sv[0], rdy_cnt);
    end
    advance();
    repeat (3) cyc();
  endtask

  task automatic test_round_robin();
    int loads;
    int idle_run;
    int idx;
    do_reset();
    req_data  = {9'h100, 9'h0FF};
    req_valid = 2'b11;
    loads = 0;
    idle_run = 0;
    for (int k = 0; k < 44; k++) begin
      sample();
      if (!o_busy[0]) idle_run++;
      if (o_load[0]) begin
        idx = (o_rdy[0] == 2'b10) ? 1 : 0;
        total++;
        if (idx != loads % 2) begin
          bad++; $display("FAIL rr_order grant%0d got=%0d want=%0d", loads, idx, loads % 2);
        end
        if (loads > 0) begin
          total++;
          if (idle_run != 1) begin
            bad++; $display("FAIL rr_idle_gap got=%0d want=1", idle_run);
          end
        end
        idle_run = 0;
        loads++;
      end
      advance();
    end
    total++;
    if (loads != 4) begin
      bad++; $display("FAIL rr_frame_count got=%0d want=4", loads);
    end
    req_valid = '0;
    repeat (12) cyc();
  endtask

  task automatic test_back_to_back();
    int  loads;
    bit  prev_last;
    do_reset();
    req_data  = {9'h155, 9'h000};
    req_valid = 2'b10;
    loads = 0;
    prev_last = 1'b0;
    for (int k = 0; k < 40; k++) begin
      sample();
      if (o_load[1]) loads++;
      if (k > 0) begin
        total++;
        if (o_sv[1] !== 1'b1 || o_sl[1] !== o_load[1] || (prev_last && o_sf[1] !== 1'b1)) begin
          bad++;
          $display("FAIL b2b_cycle%0d got sv=%b last=%b load=%b first=%b want sv=1 last=load", k,
                   o_sv[1], o_sl[1], o_load[1], o_sf[1]);
        end
      end
      prev_last = o_sl[1];
      advance();
    end
    total++;
    if (loads != 5) begin
      bad++; $display("FAIL b2b_frame_count got=%0d want=5", loads);
    end
    req_valid = '0;
    repeat (12) cyc();
  endtask

  task automatic test_reset_midframe();
    req_data  = {9'h0F0, 9'h13C};
    req_valid = 2'b01;
    cyc();
    req_valid = '0;
    repeat (3) cyc();
    rst_n = 1'b0;
    cyc();
    req_valid = 2'b11;
    sample();
    for (int u = 0; u < 2; u++) begin
      total++;
      if ({o_rdy[u], o_load[u], o_pdata[u], o_sv[u], o_sf[u], o_sl[u], o_src[u], o_busy[u]} !== '0) begin
        bad++;
        $display("FAIL midreset_outputs inst%0d got=%h want=0", u,
                 {o_rdy[u], o_load[u], o_pdata[u], o_sv[u], o_sf[u], o_sl[u], o_src[u], o_busy[u]});
      end
    end
    advance();
    rst_n = 1'b1;
    sample();
    for (int u = 0; u < 2; u++) begin
      total++;
      if (o_rdy[u] !== 2'b01) begin
        bad++; $display("FAIL midreset_first_grant inst%0d got=%b want=01", u, o_rdy[u]);
      end
    end
    advance();
    req_valid = '0;
    repeat (12) cyc();
  endtask

  task automatic test_drop_valid();
    logic [W-1:0] bits;
    int           loads;
    do_reset();
    req_data  = {9'h0C3, 9'h1FF};
    req_valid = 2'b10;
    cyc();
    loads = 0;
    bits  = '0;
    for (int k = 1; k <= 11; k++) begin
      req_valid = (k >= 2 && k <= 4) ? 2'b01 : 2'b00;
      req_data  = (N*W)'({$urandom(), $urandom()});
      sample();
      if (o_load[0] || o_load[1] || o_rdy[0] != '0 || o_rdy[1] != '0) loads++;
      if (k <= W) bits[k-1] = ser_bit[0];
      advance();
    end
    total++;
    if (loads != 0) begin
      bad++; $display("FAIL drop_no_handshake got=%0d want=0", loads);
    end
    total++;
    if (bits !== 9'h0C3) begin
      bad++; $display("FAIL drop_frame_bits got=%h want=0c3", bits);
    end
    sample();
    total++;
    if (o_busy[0] !== 1'b0 || o_busy[1] !== 1'b0) begin
      bad++; $display("FAIL drop_idle got=%b%b want=00", o_busy[0], o_busy[1]);
    end
    advance();
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      rst_n     = ($urandom_range(0, 59) != 0);
      req_valid = N'($urandom());
      req_data  = (N*W)'({$urandom(), $urandom()});
      cyc();
    end
    rst_n = 1'b1;
    req_valid = '0;
    repeat (12) cyc();
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_round_robin();
    test_back_to_back();
    test_reset_midframe();
    test_drop_valid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
